// File: rtl/dbgnoc_na_output_wb_vc.sv
`default_nettype none
// ============================================================================
// Module   : dbgnoc_na_output_wb_vc
// Brief    : Wishbone slave feeding per-channel flit FIFOs into one NoC output,
//            with round-robin arbitration and packet-level output locking.
// Revision : 1.0
// ============================================================================
module dbgnoc_na_output_wb_vc #(
  parameter int NOC_DATA_WIDTH = 16,
  parameter int NOC_TYPE_WIDTH = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int NUM_VC         = 2,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic [NOC_TYPE_WIDTH+NOC_DATA_WIDTH-1:0] noc_out_flit,
  output logic                                   noc_out_valid,
  input  logic                                   noc_out_ready,
  input  logic [ADDRESS_WIDTH-1:0]               wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]                  wbs_dat_i,
  input  logic                                   wbs_we_i,
  input  logic                                   wbs_cyc_i,
  input  logic                                   wbs_stb_i,
  output logic [DATA_WIDTH-1:0]                  wbs_dat_o,
  output logic                                   wbs_ack_o,
  output logic                                   wbs_err_o,
  output logic                                   wbs_rty_o
);

  localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW  = NOC_TYPE_WIDTH + NOC_DATA_WIDTH;
  localparam logic [VCW:0] NUM_VC_C = (VCW + 1)'(NUM_VC);

  // Address decode
  logic [2:0]     sel;
  logic [VCW-1:0] ch;
  logic           ch_ok;
  logic           req;

  // Response registers
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  // Push staged one cycle so a flit only shows up after its ack
  logic           push_q, push_d;
  logic [VCW-1:0] push_ch_q, push_ch_d;
  logic [FW-1:0]  push_flit_q, push_flit_d;

  // Channel FIFOs
  logic [FW-1:0] mem_q     [NUM_VC][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q  [NUM_VC];
  logic [PW-1:0] wr_ptr_d  [NUM_VC];
  logic [PW-1:0] rd_ptr_q  [NUM_VC];
  logic [PW-1:0] rd_ptr_d  [NUM_VC];
  logic [CW-1:0] count_q   [NUM_VC];
  logic [CW-1:0] count_d   [NUM_VC];
  logic [NUM_VC-1:0] empty_v;
  logic [NUM_VC-1:0] full_v;

  logic          sel_full;
  logic          sel_empty;
  logic [CW-1:0] sel_count;
  logic [DATA_WIDTH-1:0] status;

  // Arbitration and lock
  logic           lock_q, lock_d;
  logic [VCW-1:0] lock_ch_q, lock_ch_d;
  logic [VCW-1:0] last_q, last_d;
  logic [VCW-1:0] grant;
  logic           rr_found;
  int             rr_idx;
  logic [FW-1:0]  head;
  logic           xfer;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign sel   = wbs_adr_i[4:2];
  assign ch    = wbs_adr_i[5 +: VCW];
  assign ch_ok = ({1'b0, ch} < NUM_VC_C);
  assign req   = wbs_cyc_i & wbs_stb_i & ~(ack_q | err_q);

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      empty_v[i] = (count_q[i] == '0);
      full_v[i]  = (count_q[i] == CW'(FIFO_DEPTH));
    end
  end

  always_comb begin
    sel_full  = 1'b0;
    sel_empty = 1'b0;
    sel_count = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (ch == VCW'(i)) begin
        sel_full  = full_v[i];
        sel_empty = empty_v[i];
        sel_count = count_q[i];
      end
    end
  end

  always_comb begin
    status            = '0;
    status[CW-1:0]    = sel_count;
    status[16]        = sel_full;
    status[17]        = sel_empty;
    status[18]        = lock_q && (lock_ch_q == ch);
  end

  // Bus response and push decision, both taken at the request sample edge
  always_comb begin
    ack_d       = 1'b0;
    err_d       = 1'b0;
    dat_d       = '0;
    push_d      = 1'b0;
    push_ch_d   = ch;
    push_flit_d = {sel[1:0], wbs_dat_i[NOC_DATA_WIDTH-1:0]};
    if (req) begin
      if (!ch_ok || (sel > 3'd4)) begin
        err_d = 1'b1;
      end else if (wbs_we_i) begin
        if (sel[2] || sel_full) begin
          err_d = 1'b1;
        end else begin
          ack_d  = 1'b1;
          push_d = 1'b1;
        end
      end else begin
        ack_d = 1'b1;
        if (sel[2]) dat_d = status;
      end
    end
  end

  // Unlocked: first non-empty channel after the last-served one
  always_comb begin
    grant    = last_q;
    rr_found = 1'b0;
    rr_idx   = 0;
    if (lock_q) begin
      grant = lock_ch_q;
    end else begin
      for (int k = 1; k <= NUM_VC; k++) begin
        rr_idx = (int'(last_q) + k) % NUM_VC;
        if (!rr_found && !empty_v[rr_idx]) begin
          grant    = VCW'(rr_idx);
          rr_found = 1'b1;
        end
      end
    end
  end

  assign head          = mem_q[grant][rd_ptr_q[grant]];
  assign noc_out_valid = ~empty_v[grant];
  assign noc_out_flit  = noc_out_valid ? head : '0;
  assign xfer          = noc_out_valid & noc_out_ready;

  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    last_d    = last_q;
    if (xfer) begin
      last_d = grant;
      case (head[FW-1 -: NOC_TYPE_WIDTH])
        2'b01: begin
          lock_d    = 1'b1;
          lock_ch_d = grant;
        end
        2'b10, 2'b11: lock_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push_q && (push_ch_q == VCW'(i))) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
      if (xfer && (grant == VCW'(i)))       rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
      case ({push_q && (push_ch_q == VCW'(i)), xfer && (grant == VCW'(i))})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      dat_q       <= '0;
      push_q      <= 1'b0;
      push_ch_q   <= '0;
      push_flit_q <= '0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      last_q      <= VCW'(NUM_VC - 1);
      for (int i = 0; i < NUM_VC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      ack_q       <= ack_d;
      err_q       <= err_d;
      dat_q       <= dat_d;
      push_q      <= push_d;
      push_ch_q   <= push_ch_d;
      push_flit_q <= push_flit_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      last_q      <= last_d;
      for (int i = 0; i < NUM_VC; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  // Storage needs no reset: contents are only observable through count
  always_ff @(posedge clk) begin
    if (push_q) mem_q[push_ch_q][wr_ptr_q[push_ch_q]] <= push_flit_q;
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = dat_q;
  assign wbs_rty_o = 1'b0;

  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[ADDRESS_WIDTH-1:5+VCW], wbs_adr_i[1:0]};

  generate
    if (DATA_WIDTH > NOC_DATA_WIDTH) begin : g_dat_unused
      logic unused_dat;
      assign unused_dat = ^wbs_dat_i[DATA_WIDTH-1:NOC_DATA_WIDTH];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dbgnoc_na_output_wb_vc.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbgnoc_na_output_wb_vc
// Brief    : Directed self-checking bench for dbgnoc_na_output_wb_vc.
// Revision : 1.0
// ============================================================================
module tb_dbgnoc_na_output_wb_vc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] noc_out_flit;
  logic        noc_out_valid;
  logic        noc_out_ready = 1'b0;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_we_i  = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        wbs_rty_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        r_ack, r_err, r_vld;
  logic [31:0] r_dat;
  logic [17:0] out_q[$];

  dbgnoc_na_output_wb_vc dut (
    .clk          (clk),
    .rst          (rst),
    .noc_out_flit (noc_out_flit),
    .noc_out_valid(noc_out_valid),
    .noc_out_ready(noc_out_ready),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_dat_o    (wbs_dat_o),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_err_o    (wbs_err_o),
    .wbs_rty_o    (wbs_rty_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && noc_out_valid && noc_out_ready) out_q.push_back(noc_out_flit);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    out_q.delete();
  endtask

  // One single-beat request; returns one cycle after the response cycle
  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                    input logic pop);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;
    if (pop) noc_out_ready = 1'b1;
    @(posedge clk); #1;
    if (pop) noc_out_ready = 1'b0;
    r_ack = wbs_ack_o; r_err = wbs_err_o; r_dat = wbs_dat_o; r_vld = noc_out_valid;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(noc_out_valid), 32'h0);
    check("rst_flit",  32'(noc_out_flit),  32'h0);
    check("rst_ack",   32'(wbs_ack_o),     32'h0);
    check("rst_err",   32'(wbs_err_o),     32'h0);
    check("rst_dat",   wbs_dat_o,          32'h0);
    check("rty_tied",  32'(wbs_rty_o),     32'h0);
    rst = 1'b1;

    // Single-flit packet
    wb(1'b1, 32'h0C, 32'h1234, 1'b0);
    check("single_ack",        32'(r_ack), 32'h1);
    check("single_err",        32'(r_err), 32'h0);
    check("single_no_early_v", 32'(r_vld), 32'h0);
    check("single_wdat_zero",  r_dat,      32'h0);
    check("single_valid",      32'(noc_out_valid), 32'h1);
    check("single_flit",       32'(noc_out_flit),  32'h31234);
    @(posedge clk); #1;
    check("stall_valid", 32'(noc_out_valid), 32'h1);
    check("stall_flit",  32'(noc_out_flit),  32'h31234);
    noc_out_ready = 1'b1;
    @(posedge clk); #1;
    noc_out_ready = 1'b0;
    check("single_popped_v", 32'(noc_out_valid), 32'h0);
    check("single_popped_f", 32'(noc_out_flit),  32'h0);
    wb(1'b0, 32'h00, 32'h0, 1'b0);
    check("rd_sel0_ack", 32'(r_ack), 32'h1);
    check("rd_sel0_dat", r_dat,      32'h0);
    check("dat_idle",    wbs_dat_o,  32'h0);

    // Request held through its response cycle is taken once
    do_reset();
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h2C; wbs_dat_i = 32'h55;
    @(posedge clk); #1;
    check("hold_ack1", 32'(wbs_ack_o), 32'h1);
    @(posedge clk); #1;
    check("hold_ack2", 32'({wbs_ack_o, wbs_err_o}), 32'h0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge clk); #1;
    wb(1'b0, 32'h30, 32'h0, 1'b0);
    check("hold_status_ch1", r_dat, 32'h00001);

    // Interleave prevention
    do_reset();
    noc_out_ready = 1'b1;
    wb(1'b1, 32'h04, 32'hA, 1'b0);
    wb(1'b1, 32'h2C, 32'hC, 1'b0);
    repeat (2) @(posedge clk);
    wb(1'b1, 32'h00, 32'hB, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("il_count2", 32'(out_q.size()), 32'd2);
    check("il_out0",   32'(out_q[0]),     32'h1000A);
    check("il_out1",   32'(out_q[1]),     32'h0000B);
    check("il_stalled", 32'(noc_out_valid), 32'h0);
    wb(1'b0, 32'h10, 32'h0, 1'b0);
    check("il_status_ch0_locked", r_dat, 32'h60000);
    wb(1'b0, 32'h30, 32'h0, 1'b0);
    check("il_status_ch1_wait",   r_dat, 32'h00001);
    wb(1'b1, 32'h08, 32'hD, 1'b0);
    repeat (4) @(posedge clk); #1;
    check("il_count4", 32'(out_q.size()), 32'd4);
    check("il_out2",   32'(out_q[2]),     32'h2000D);
    check("il_out3",   32'(out_q[3]),     32'h3000C);
    noc_out_ready = 1'b0;
    wb(1'b0, 32'h10, 32'h0, 1'b0);
    check("il_status_ch0_free", r_dat, 32'h20000);

    // Round robin
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wb(1'b1, 32'h0C, 32'h10 + 32'(i), 1'b0);
      wb(1'b1, 32'h2C, 32'h20 + 32'(i), 1'b0);
    end
    check("rr_none_yet", 32'(out_q.size()), 32'd0);
    @(negedge clk);
    noc_out_ready = 1'b1;
    repeat (8) @(negedge clk);
    noc_out_ready = 1'b0;
    check("rr_count", 32'(out_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_out%0d", i), 32'(out_q[i]),
            32'h30000 + ((i % 2 == 1) ? 32'h20 : 32'h10) + 32'(i / 2));
    end

    // Full FIFO
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wb(1'b1, 32'h20, 32'(i), 1'b0);
      check($sformatf("full_wr%0d_ack", i), 32'({r_ack, r_err}), 32'h2);
    end
    wb(1'b1, 32'h20, 32'h77, 1'b0);
    check("full_17th", 32'({r_ack, r_err}), 32'h1);
    wb(1'b0, 32'h30, 32'h0, 1'b0);
    check("full_status", r_dat, 32'h10010);
    wb(1'b1, 32'h20, 32'h99, 1'b1);
    check("full_pop_same_cycle", 32'({r_ack, r_err}), 32'h1);
    wb(1'b0, 32'h30, 32'h0, 1'b0);
    check("full_after_pop", r_dat, 32'h0000F);

    // Error decode
    do_reset();
    wb(1'b1, 32'h18, 32'h1, 1'b0);
    check("err_sel6", 32'({r_ack, r_err}), 32'h1);
    wb(1'b1, 32'h10, 32'h1, 1'b0);
    check("err_wr_status", 32'({r_ack, r_err}), 32'h1);
    wb(1'b0, 32'h3C, 32'h0, 1'b0);
    check("err_rd_sel7", 32'({r_ack, r_err, 8'(r_dat)}), 32'h100);
    wb(1'b0, 32'h10, 32'h0, 1'b0);
    check("err_status_ch0", r_dat, 32'h20000);
    wb(1'b0, 32'h30, 32'h0, 1'b0);
    check("err_status_ch1", r_dat, 32'h20000);

    // Reset in the middle of a locked packet
    do_reset();
    wb(1'b1, 32'h04, 32'h1, 1'b0);
    wb(1'b1, 32'h00, 32'h2, 1'b0);
    wb(1'b1, 32'h00, 32'h3, 1'b0);
    @(negedge clk);
    noc_out_ready = 1'b1;
    @(negedge clk);
    noc_out_ready = 1'b0;
    wb(1'b0, 32'h10, 32'h0, 1'b0);
    check("mr_locked_status", r_dat, 32'h40002);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h2C; wbs_dat_i = 32'h5;
    rst = 1'b0;
    #1;
    check("mr_valid_now", 32'(noc_out_valid), 32'h0);
    check("mr_ack_now",   32'(wbs_ack_o),     32'h0);
    @(posedge clk); #1;
    check("mr_no_resp", 32'({wbs_ack_o, wbs_err_o}), 32'h0);
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mr_after_resp", 32'({wbs_ack_o, wbs_err_o, noc_out_valid}), 32'h0);
    wb(1'b0, 32'h10, 32'h0, 1'b0);
    check("mr_status_ch0", r_dat, 32'h20000);
    wb(1'b0, 32'h30, 32'h0, 1'b0);
    check("mr_status_ch1", r_dat, 32'h20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
